// File: rtl/id_hazard_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_hazard_ctrl_pkg                                                   |
// | Shared encodings and instruction field positions for ID issue control|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package id_hazard_ctrl_pkg;

    localparam int REG_W = 4;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_BR_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 25;
    localparam int IMMF_B  = 24;
    localparam int RD_HI   = 23;
    localparam int RD_LO   = 20;
    localparam int RS_HI   = 19;
    localparam int RS_LO   = 16;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;

    typedef logic [REG_W-1:0] reg_idx_t;

    function automatic reg_idx_t inst_rd(input logic [31:0] inst);
        return inst[RD_HI:RD_LO];
    endfunction

    function automatic reg_idx_t inst_rs(input logic [31:0] inst);
        return inst[RS_HI:RS_LO];
    endfunction

    function automatic logic inst_immf(input logic [31:0] inst);
        return inst[IMMF_B];
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_hazard_ctrl_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_hazard_ctrl_scoreboard                                            |
// | Per-register saturating pending-write counters with two read ports   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module id_hazard_ctrl_scoreboard
    import id_hazard_ctrl_pkg::*;
#(
    parameter int NREG   = 16,
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_en,
    input  logic [REG_W-1:0]  inc_r,
    input  logic              dec_en,
    input  logic [REG_W-1:0]  dec_r,
    input  logic [REG_W-1:0]  q_rd,
    input  logic [REG_W-1:0]  q_rs,
    output logic [PEND_W-1:0] cnt_rd,
    output logic [PEND_W-1:0] cnt_rs,
    output logic [NREG-1:0]   busy,
    output logic              err
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [PEND_W-1:0] cnt [NREG];
    logic [NREG-1:0]   err_bit;

    generate
        for (genvar r = 0; r < NREG; r++) begin : g_reg
            logic              inc_hit;
            logic              dec_hit;
            logic [PEND_W-1:0] cnt_q;
            logic              err_q;

            assign inc_hit = inc_en && (inc_r == REG_W'(r));
            assign dec_hit = dec_en && (dec_r == REG_W'(r));

            // Coincident issue and retire cancel; underflow is held at zero and flagged.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                    err_q <= 1'b0;
                end else if (inc_hit && !dec_hit) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + PEND_W'(1);
                    end
                end else if (dec_hit && !inc_hit) begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - PEND_W'(1);
                    end else begin
                        err_q <= 1'b1;
                    end
                end
            end

            assign cnt[r]     = cnt_q;
            assign err_bit[r] = err_q;
            assign busy[r]    = |cnt_q;
        end
    endgenerate

    assign cnt_rd = cnt[q_rd];
    assign cnt_rs = cnt[q_rs];
    assign err    = |err_bit;

endmodule
`default_nettype wire

// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_hazard_ctrl                                                       |
// | ID-stage issue/hazard control: scoreboard, branch wait and flush FSM |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int NREG         = 16,
    parameter int PEND_W       = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int WB_BYPASS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic             id_rd_rd_i,
    input  logic             id_rs_rd_i,
    input  logic             id_wr_i,
    input  logic             id_br_i,
    input  logic             wb_i,
    input  logic [REG_W-1:0] wb_r_i,
    input  logic             br_resolve_i,
    input  logic             br_taken_i,
    input  logic             mem_stall_i,
    output logic             issue_o,
    output logic             stall_o,
    output logic             flush_o,
    output logic [NREG-1:0]  busy_o
);

    localparam int                FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0]   FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);
    localparam logic              BYPASS  = (WB_BYPASS != 0);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [FC_W-1:0]   fcnt;
    logic [FC_W-1:0]   fcnt_nxt;
    logic [PEND_W-1:0] cnt_rd;
    logic [PEND_W-1:0] cnt_rs;
    logic              sb_err;
    logic              rd_retire;
    logic              rs_retire;
    logic              rd_hz;
    logic              rs_hz;
    logic              src_hz;
    logic              waw_hz;

    id_hazard_ctrl_scoreboard #(
        .NREG   (NREG),
        .PEND_W (PEND_W)
    ) u_sb (
        .clk    (clk),
        .rst    (rst),
        .inc_en (issue_o && id_wr_i),
        .inc_r  (id_rd_i),
        .dec_en (wb_i),
        .dec_r  (wb_r_i),
        .q_rd   (id_rd_i),
        .q_rs   (id_rs_i),
        .cnt_rd (cnt_rd),
        .cnt_rs (cnt_rs),
        .busy   (busy_o),
        .err    (sb_err)
    );

    // A source whose last pending write retires this cycle can take the writeback value.
    assign rd_retire = BYPASS && wb_i && (wb_r_i == id_rd_i) && (cnt_rd == CNT_ONE);
    assign rs_retire = BYPASS && wb_i && (wb_r_i == id_rs_i) && (cnt_rs == CNT_ONE);
    assign rd_hz     = id_rd_rd_i && (cnt_rd != '0) && !rd_retire;
    assign rs_hz     = id_rs_rd_i && (cnt_rs != '0) && !rs_retire;
    assign src_hz    = rd_hz || rs_hz;
    assign waw_hz    = id_wr_i && (cnt_rd == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
            fcnt  <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        case (state)
            ST_RUN: begin
                if (issue_o && id_br_i) begin
                    state_nxt = ST_BR_WAIT;
                end
            end
            ST_BR_WAIT: begin
                if (br_resolve_i) begin
                    if (br_taken_i) begin
                        state_nxt = ST_FLUSH;
                        fcnt_nxt  = FC_LOAD;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_FLUSH: begin
                if (fcnt == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    fcnt_nxt = fcnt - FC_W'(1);
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_comb begin
        issue_o = 1'b0;
        stall_o = 1'b0;
        if (rst) begin
            case (state)
                ST_RUN: begin
                    issue_o = id_valid_i && !mem_stall_i && !src_hz && !waw_hz;
                    stall_o = id_valid_i && !issue_o;
                end
                ST_BR_WAIT: begin
                    stall_o = 1'b1;
                end
                default: begin
                    stall_o = 1'b0;
                end
            endcase
        end
    end

    assign flush_o = (state == ST_FLUSH);

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !sb_err);

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_id_hazard_ctrl                                                    |
// | Directed self-checking bench for id_hazard_ctrl                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_id_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid_i, id_rd_rd_i, id_rs_rd_i, id_wr_i, id_br_i;
    logic [3:0]  id_rd_i, id_rs_i, wb_r_i;
    logic        wb_i, br_resolve_i, br_taken_i, mem_stall_i;
    logic        issue_o, stall_o, flush_o;
    logic [15:0] busy_o;

    int n_cmp  = 0;
    int n_fail = 0;

    id_hazard_ctrl #(
        .NREG         (16),
        .PEND_W       (2),
        .FLUSH_CYCLES (2),
        .WB_BYPASS    (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid_i   (id_valid_i),
        .id_rd_i      (id_rd_i),
        .id_rs_i      (id_rs_i),
        .id_rd_rd_i   (id_rd_rd_i),
        .id_rs_rd_i   (id_rs_rd_i),
        .id_wr_i      (id_wr_i),
        .id_br_i      (id_br_i),
        .wb_i         (wb_i),
        .wb_r_i       (wb_r_i),
        .br_resolve_i (br_resolve_i),
        .br_taken_i   (br_taken_i),
        .mem_stall_i  (mem_stall_i),
        .issue_o      (issue_o),
        .stall_o      (stall_o),
        .flush_o      (flush_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid_i = 0; id_rd_i = 0; id_rs_i = 0; id_rd_rd_i = 0; id_rs_rd_i = 0;
        id_wr_i = 0; id_br_i = 0; wb_i = 0; wb_r_i = 0;
        br_resolve_i = 0; br_taken_i = 0; mem_stall_i = 0;
    endtask

    task automatic instr(input logic [3:0] rd, input logic [3:0] rs, input logic rdrd,
                         input logic rsrd, input logic wr, input logic br);
        id_valid_i = 1; id_rd_i = rd; id_rs_i = rs;
        id_rd_rd_i = rdrd; id_rs_rd_i = rsrd; id_wr_i = wr; id_br_i = br;
    endtask

    task automatic test_reset();
        idle();
        instr(4'd2, 4'd1, 1, 1, 1, 0);
        #2;
        n_cmp++; if (issue_o !== 1'b0) begin n_fail++; $display("FAIL rst_issue: got %b want 0", issue_o); end
        n_cmp++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall_o); end
        n_cmp++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b want 0", flush_o); end
        n_cmp++; if (busy_o !== 16'h0000) begin n_fail++; $display("FAIL rst_busy: got %h want 0000", busy_o); end
        step();
        idle();
        step();
        rst = 1'b1;
        step();
        n_cmp++; if (busy_o !== 16'h0000) begin n_fail++; $display("FAIL rst_busy_after: got %h want 0000", busy_o); end
    endtask

    task automatic test_raw_bypass();
        instr(4'd3, 4'd1, 1, 1, 1, 0);
        #1;
        n_cmp++; if (issue_o !== 1'b1) begin n_fail++; $display("FAIL raw_writer_issue: got %b want 1", issue_o); end
        step();
        n_cmp++; if (busy_o !== 16'h0008) begin n_fail++; $display("FAIL raw_busy3: got %h want 0008", busy_o); end
        instr(4'd4, 4'd3, 0, 1, 1, 0);
        #1;
        n_cmp++; if (stall_o !== 1'b1 || issue_o !== 1'b0) begin n_fail++; $display("FAIL raw_stall1: got stall=%b issue=%b want 1/0", stall_o, issue_o); end
        step();
        n_cmp++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL raw_stall2: got %b want 1", stall_o); end
        wb_i = 1; wb_r_i = 4'd3;
        #1;
        n_cmp++; if (issue_o !== 1'b1 || stall_o !== 1'b0) begin n_fail++; $display("FAIL raw_bypass_issue: got issue=%b stall=%b want 1/0", issue_o, stall_o); end
        step();
        idle();
        n_cmp++; if (busy_o !== 16'h0010) begin n_fail++; $display("FAIL raw_busy_after_wb: got %h want 0010", busy_o); end
        wb_i = 1; wb_r_i = 4'd4;
        step();
        idle();
        n_cmp++; if (busy_o !== 16'h0000) begin n_fail++; $display("FAIL raw_drain: got %h want 0000", busy_o); end
    endtask

    task automatic test_waw_cap();
        for (int i = 0; i < 3; i++) begin
            instr(4'd5, 4'd0, 0, 0, 1, 0);
            #1;
            n_cmp++; if (issue_o !== 1'b1) begin n_fail++; $display("FAIL waw_fill%0d: got %b want 1", i, issue_o); end
            step();
        end
        // count is now at the 2-bit maximum of 3
        #1;
        n_cmp++; if (issue_o !== 1'b0 || stall_o !== 1'b1) begin n_fail++; $display("FAIL waw_cap: got issue=%b stall=%b want 0/1", issue_o, stall_o); end
        step();
        wb_i = 1; wb_r_i = 4'd5;
        #1;
        n_cmp++; if (issue_o !== 1'b0) begin n_fail++; $display("FAIL waw_cap_wb: got %b want 0", issue_o); end
        step();
        #1;
        n_cmp++; if (issue_o !== 1'b1) begin n_fail++; $display("FAIL waw_issue_with_wb: got %b want 1", issue_o); end
        step();
        wb_i = 0;
        #1;
        n_cmp++; if (issue_o !== 1'b1) begin n_fail++; $display("FAIL waw_refill: got %b want 1", issue_o); end
        step();
        #1;
        n_cmp++; if (issue_o !== 1'b0) begin n_fail++; $display("FAIL waw_cap_again: got %b want 0", issue_o); end
        idle();
        wb_i = 1; wb_r_i = 4'd5;
        step(); step();
        n_cmp++; if (busy_o !== 16'h0020) begin n_fail++; $display("FAIL waw_drain2: got %h want 0020", busy_o); end
        step();
        idle();
        n_cmp++; if (busy_o !== 16'h0000) begin n_fail++; $display("FAIL waw_drain3: got %h want 0000", busy_o); end
    endtask

    task automatic test_branch_taken();
        instr(4'd0, 4'd0, 0, 0, 0, 1);
        #1;
        n_cmp++; if (issue_o !== 1'b1) begin n_fail++; $display("FAIL bt_issue: got %b want 1", issue_o); end
        step();
        instr(4'd6, 4'd0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (stall_o !== 1'b1 || issue_o !== 1'b0) begin n_fail++; $display("FAIL bt_wait: got stall=%b issue=%b want 1/0", stall_o, issue_o); end
        step();
        br_resolve_i = 1; br_taken_i = 1;
        #1;
        n_cmp++; if (stall_o !== 1'b1 || flush_o !== 1'b0) begin n_fail++; $display("FAIL bt_resolve: got stall=%b flush=%b want 1/0", stall_o, flush_o); end
        step();
        br_resolve_i = 0; br_taken_i = 0;
        #1;
        n_cmp++; if (flush_o !== 1'b1 || stall_o !== 1'b0 || issue_o !== 1'b0) begin n_fail++; $display("FAIL bt_flush1: got flush=%b stall=%b issue=%b want 1/0/0", flush_o, stall_o, issue_o); end
        step();
        n_cmp++; if (flush_o !== 1'b1 || issue_o !== 1'b0) begin n_fail++; $display("FAIL bt_flush2: got flush=%b issue=%b want 1/0", flush_o, issue_o); end
        step();
        n_cmp++; if (flush_o !== 1'b0 || issue_o !== 1'b1) begin n_fail++; $display("FAIL bt_run: got flush=%b issue=%b want 0/1", flush_o, issue_o); end
        idle();
        br_resolve_i = 1; br_taken_i = 1;
        step();
        idle();
        n_cmp++; if (flush_o !== 1'b0 || stall_o !== 1'b0) begin n_fail++; $display("FAIL bt_resolve_ignored: got flush=%b stall=%b want 0/0", flush_o, stall_o); end
        step();
    endtask

    task automatic test_branch_not_taken();
        instr(4'd0, 4'd0, 0, 0, 0, 1);
        #1;
        n_cmp++; if (issue_o !== 1'b1) begin n_fail++; $display("FAIL bnt_issue: got %b want 1", issue_o); end
        step();
        instr(4'd6, 4'd0, 0, 0, 0, 0);
        br_resolve_i = 1; br_taken_i = 0;
        #1;
        n_cmp++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL bnt_wait: got %b want 1", stall_o); end
        step();
        br_resolve_i = 0;
        #1;
        n_cmp++; if (flush_o !== 1'b0 || issue_o !== 1'b1) begin n_fail++; $display("FAIL bnt_run: got flush=%b issue=%b want 0/1", flush_o, issue_o); end
        step();
        idle();
        n_cmp++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL bnt_noflush: got %b want 0", flush_o); end
    endtask

    task automatic test_mem_stall();
        instr(4'd9, 4'd0, 0, 0, 1, 0);
        mem_stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (issue_o !== 1'b0 || stall_o !== 1'b1) begin n_fail++; $display("FAIL ms_hold%0d: got issue=%b stall=%b want 0/1", i, issue_o, stall_o); end
            step();
            n_cmp++; if (busy_o !== 16'h0000) begin n_fail++; $display("FAIL ms_busy%0d: got %h want 0000", i, busy_o); end
        end
        mem_stall_i = 0;
        #1;
        n_cmp++; if (issue_o !== 1'b1 || stall_o !== 1'b0) begin n_fail++; $display("FAIL ms_release: got issue=%b stall=%b want 1/0", issue_o, stall_o); end
        step();
        idle();
        n_cmp++; if (busy_o !== 16'h0200) begin n_fail++; $display("FAIL ms_busy9: got %h want 0200", busy_o); end
        wb_i = 1; wb_r_i = 4'd9;
        step();
        idle();
        n_cmp++; if (busy_o !== 16'h0000) begin n_fail++; $display("FAIL ms_drain: got %h want 0000", busy_o); end
    endtask

    task automatic test_reset_mid_branch();
        instr(4'd7, 4'd0, 0, 0, 1, 1);
        #1;
        n_cmp++; if (issue_o !== 1'b1) begin n_fail++; $display("FAIL rmb_issue: got %b want 1", issue_o); end
        step();
        instr(4'd8, 4'd7, 0, 1, 0, 0);
        #1;
        n_cmp++; if (busy_o !== 16'h0080 || stall_o !== 1'b1) begin n_fail++; $display("FAIL rmb_wait: got busy=%h stall=%b want 0080/1", busy_o, stall_o); end
        rst = 1'b0;
        #1;
        n_cmp++; if (flush_o !== 1'b0 || busy_o !== 16'h0000) begin n_fail++; $display("FAIL rmb_async: got flush=%b busy=%h want 0/0000", flush_o, busy_o); end
        n_cmp++; if (issue_o !== 1'b0 || stall_o !== 1'b0) begin n_fail++; $display("FAIL rmb_gate: got issue=%b stall=%b want 0/0", issue_o, stall_o); end
        step();
        rst = 1'b1;
        #1;
        n_cmp++; if (issue_o !== 1'b1 || stall_o !== 1'b0) begin n_fail++; $display("FAIL rmb_reader: got issue=%b stall=%b want 1/0", issue_o, stall_o); end
        step();
        idle();
        n_cmp++; if (flush_o !== 1'b0 || stall_o !== 1'b0) begin n_fail++; $display("FAIL rmb_run: got flush=%b stall=%b want 0/0", flush_o, stall_o); end
    endtask

    initial begin
        idle();
        test_reset();
        test_raw_bypass();
        test_waw_cap();
        test_branch_taken();
        test_branch_not_taken();
        test_mem_stall();
        test_reset_mid_branch();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
